// File: rtl/rdata_channel.sv
// rdata_channel: turns queued read-burst descriptors {id, len} plus a stream
// of DDR read-data words into AXI-style R-channel beats with rid/rlast.
// A 2-entry descriptor FIFO decouples the request side from the streaming
// engine; a single output register holds the current R beat.
module rdata_channel (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_id,
    input  logic [7:0]  req_len,
    input  logic        dat_valid,
    output logic        dat_ready,
    input  logic [31:0] dat_in,
    output logic        rvalid,
    input  logic        rready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic        rlast,
    output logic [1:0]  rresp,
    output logic        busy
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    localparam int DEPTH = 2;

    // Descriptor FIFO storage and bookkeeping
    logic [3:0] fifo_id_q  [DEPTH];
    logic [7:0] fifo_len_q [DEPTH];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] occ_q;

    // Streaming engine state
    state_t     state_q;
    logic [3:0] active_id_q;
    logic [7:0] active_len_q;
    logic [8:0] count_q;

    // R-channel output register
    logic        rvalid_q;
    logic        rlast_q;
    logic [3:0]  rid_q;
    logic [31:0] rdata_q;

    logic push;
    logic pop;
    logic beat_acc;
    logic last_beat;

    // Ready is derived from registered occupancy only, never from a same-cycle pop
    assign req_ready = (occ_q < 2'd2);
    assign push      = req_valid & req_ready;
    assign pop       = (state_q == ST_IDLE) & (occ_q != 2'd0);

    // Accept data only while streaming and the output slot is free or draining
    assign dat_ready = (state_q == ST_STREAM) & (~rvalid_q | rready);
    assign beat_acc  = dat_valid & dat_ready;

    // 9-bit compare so len=255 reaches count 255 without wrapping
    assign last_beat = (count_q == {1'b0, active_len_q});

    assign rvalid = rvalid_q;
    assign rlast  = rlast_q;
    assign rid    = rid_q;
    assign rdata  = rdata_q;
    assign rresp  = 2'b00;
    assign busy   = (state_q == ST_STREAM) | (occ_q != 2'd0) | rvalid_q;

    // Descriptor FIFO: write at wr_ptr, read at rd_ptr, occupancy tracks push/pop
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_id_q[i]  <= '0;
                fifo_len_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) begin
                fifo_id_q[wr_ptr_q]  <= req_id;
                fifo_len_q[wr_ptr_q] <= req_len;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // IDLE/STREAM sequencer: load the head descriptor, count beats, leave on the last one
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            active_id_q  <= '0;
            active_len_q <= '0;
            count_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        active_id_q  <= fifo_id_q[rd_ptr_q];
                        active_len_q <= fifo_len_q[rd_ptr_q];
                        count_q      <= '0;
                        state_q      <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (beat_acc) begin
                        count_q <= count_q + 9'd1;
                        if (last_beat) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Output beat register: load on accept, drop valid when drained without a refill
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rid_q    <= '0;
            rdata_q  <= '0;
        end else begin
            if (beat_acc) begin
                rvalid_q <= 1'b1;
                rdata_q  <= dat_in;
                rid_q    <= active_id_q;
                rlast_q  <= last_beat;
            end else if (rvalid_q & rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rdata_channel.sv
// Bench for rdata_channel: a queue-based behavioural model checked every
// cycle, plus directed scenarios with literal expectations on the beat log.
module tb_rdata_channel;

    logic        clk;
    logic        n_rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_id;
    logic [7:0]  req_len;
    logic        dat_valid;
    logic        dat_ready;
    logic [31:0] dat_in;
    logic        rvalid;
    logic        rready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast;
    logic [1:0]  rresp;
    logic        busy;

    rdata_channel dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_id    (req_id),
        .req_len   (req_len),
        .dat_valid (dat_valid),
        .dat_ready (dat_ready),
        .dat_in    (dat_in),
        .rvalid    (rvalid),
        .rready    (rready),
        .rid       (rid),
        .rdata     (rdata),
        .rlast     (rlast),
        .rresp     (rresp),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [3:0] id;
        logic [7:0] len;
    } desc_t;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic        last;
    } beat_t;

    desc_t       mq[$];
    beat_t       blog[$];
    bit          m_active;
    int          m_left;
    logic [3:0]  m_id;
    bit          m_rvalid;
    logic [3:0]  m_rid;
    logic [31:0] m_rdata;
    bit          m_rlast;

    // Sample at the falling edge: outputs are settled and inputs are stable until the next rise
    always @(negedge clk) begin
        bit    e_req_ready;
        bit    e_dat_ready;
        bit    e_busy;
        bit    do_push;
        bit    do_acc;
        bit    do_pop;
        desc_t d;
        if (!n_rst) begin
            mq.delete();
            m_active = 0;
            m_left   = 0;
            m_id     = '0;
            m_rvalid = 0;
            m_rid    = '0;
            m_rdata  = '0;
            m_rlast  = 0;
            chk("rst_rvalid", rvalid, 0);
            chk("rst_req_ready", req_ready, 1);
            chk("rst_dat_ready", dat_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rid", rid, 0);
            chk("rst_rdata", rdata, 0);
            chk("rst_rlast", rlast, 0);
        end else begin
            e_req_ready = (mq.size() < 2);
            e_dat_ready = m_active && (!m_rvalid || rready);
            e_busy      = m_active || (mq.size() > 0) || m_rvalid;
            chk("req_ready", req_ready, e_req_ready);
            chk("dat_ready", dat_ready, e_dat_ready);
            chk("busy", busy, e_busy);
            chk("rvalid", rvalid, m_rvalid);
            chk("rresp", rresp, 0);
            if (m_rvalid) begin
                chk("rid", rid, m_rid);
                chk("rdata", rdata, m_rdata);
                chk("rlast", rlast, m_rlast);
            end
            if (rvalid && rready) begin
                blog.push_back('{id: rid, data: rdata, last: rlast});
                $display("beat %0d: rid=%0d rdata=%08h rlast=%0d", blog.size(), rid, rdata, rlast);
            end
            do_push = req_valid && e_req_ready;
            do_acc  = dat_valid && e_dat_ready;
            do_pop  = !m_active && (mq.size() > 0);
            if (do_acc) begin
                m_rvalid = 1;
                m_rid    = m_id;
                m_rdata  = dat_in;
                m_rlast  = (m_left == 1);
                m_left--;
                if (m_left == 0) m_active = 0;
            end else if (m_rvalid && rready) begin
                m_rvalid = 0;
            end
            if (do_pop) begin
                d        = mq.pop_front();
                m_active = 1;
                m_id     = d.id;
                m_left   = int'(d.len) + 1;
            end
            if (do_push) mq.push_back('{id: req_id, len: req_len});
        end
    end

    // ---------------- stimulus helpers ----------------
    int cyc        = 0;
    bit fixed_data = 0;
    bit saw_full   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (!fixed_data) dat_in = 32'hC0DE_0000 | 32'(cyc);
    endtask

    task automatic push_desc(input logic [3:0] id, input logic [7:0] len);
        int n = 0;
        req_valid = 1'b1;
        req_id    = id;
        req_len   = len;
        while (!req_ready && n < 2000) begin
            saw_full = 1;
            tick();
            n++;
        end
        if (!req_ready) chk("push_timeout", 1, 0);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int base;
        int n;
        int rl_cnt;
        int gaps;
        logic [31:0] held_data;
        logic [3:0]  held_id;
        logic [3:0]  exp_ids[4];
        int          exp_len[4];
        int          k;

        n_rst = 0; req_valid = 0; req_id = 0; req_len = 0;
        dat_valid = 0; dat_in = 0; rready = 0;
        tick(); tick();
        chk("init_req_ready", req_ready, 1);
        chk("init_busy", busy, 0);
        n_rst = 1;
        tick();

        // Single beat
        base = blog.size();
        fixed_data = 1; dat_in = 32'hA5A5_A5A5; dat_valid = 1; rready = 1;
        push_desc(4'd3, 8'd0);
        wait_idle(50);
        chk("t1_nbeats", blog.size() - base, 1);
        if (blog.size() > base) begin
            chk("t1_rid", blog[base].id, 3);
            chk("t1_rdata", blog[base].data, 32'hA5A5_A5A5);
            chk("t1_rlast", blog[base].last, 1);
        end
        fixed_data = 0; dat_valid = 0;
        tick();

        // Backpressure on the first beat of a 4-beat burst
        base = blog.size();
        rready = 0; dat_valid = 1;
        push_desc(4'd1, 8'd3);
        n = 0;
        while (!rvalid && n < 50) begin tick(); n++; end
        chk("t2_rvalid_seen", rvalid, 1);
        held_data = rdata; held_id = rid;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_rvalid", rvalid, 1);
            chk("t2_hold_rdata", rdata, held_data);
            chk("t2_hold_rid", rid, held_id);
            chk("t2_hold_dat_ready", dat_ready, 0);
        end
        rready = 1;
        wait_idle(50);
        chk("t2_nbeats", blog.size() - base, 4);
        for (int i = 0; i < 4 && base + i < blog.size(); i++) begin
            chk("t2_rid", blog[base+i].id, 1);
            chk("t2_rlast", blog[base+i].last, (i == 3) ? 1 : 0);
        end
        if (blog.size() > base) chk("t2_first_data", blog[base].data, held_data);
        dat_valid = 0;
        tick();

        // Maximum length burst
        base = blog.size();
        dat_valid = 1; rready = 1;
        push_desc(4'd2, 8'd255);
        wait_idle(600);
        chk("t3_nbeats", blog.size() - base, 256);
        rl_cnt = 0;
        for (int i = base; i < blog.size(); i++) if (blog[i].last) rl_cnt++;
        chk("t3_rlast_count", rl_cnt, 1);
        if (blog.size() > base) chk("t3_rlast_final", blog[blog.size()-1].last, 1);
        dat_valid = 0;
        tick();

        // Queue full: four descriptors back-to-back while the first streams
        base = blog.size();
        saw_full = 0;
        dat_valid = 1; rready = 1;
        exp_ids = '{4'd4, 4'd5, 4'd6, 4'd7};
        exp_len = '{8, 2, 2, 2};
        push_desc(4'd4, 8'd7);
        push_desc(4'd5, 8'd1);
        push_desc(4'd6, 8'd1);
        push_desc(4'd7, 8'd1);
        chk("t4_saw_full", saw_full, 1);
        wait_idle(100);
        chk("t4_nbeats", blog.size() - base, 14);
        k = base;
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < exp_len[b]; j++) begin
                if (k < blog.size()) begin
                    chk("t4_rid", blog[k].id, exp_ids[b]);
                    chk("t4_rlast", blog[k].last, (j == exp_len[b] - 1) ? 1 : 0);
                end
                k++;
            end
        end
        dat_valid = 0;
        tick();

        // Data starvation: dat_valid toggles
        base = blog.size();
        rready = 1; dat_valid = 0; gaps = 0;
        push_desc(4'd9, 8'd7);
        n = 0;
        while (busy && n < 100) begin
            dat_valid = ~dat_valid;
            tick();
            if (busy && !rvalid && blog.size() > base) gaps++;
            n++;
        end
        chk("t5_idle", busy, 0);
        chk("t5_nbeats", blog.size() - base, 8);
        chk("t5_gaps_seen", (gaps > 0) ? 1 : 0, 1);
        for (int i = base; i < blog.size(); i++) begin
            chk("t5_rid", blog[i].id, 9);
            chk("t5_rlast", blog[i].last, (i == blog.size() - 1) ? 1 : 0);
        end
        dat_valid = 0;
        tick();

        // Reset mid-burst with another descriptor queued
        base = blog.size();
        dat_valid = 1; rready = 1;
        push_desc(4'd5, 8'd5);
        push_desc(4'd6, 8'd1);
        n = 0;
        while (blog.size() < base + 2 && n < 50) begin tick(); n++; end
        chk("t6_two_beats", blog.size() - base, 2);
        n_rst = 0;
        #1;
        chk("t6_imm_rvalid", rvalid, 0);
        chk("t6_imm_busy", busy, 0);
        chk("t6_imm_req_ready", req_ready, 1);
        chk("t6_imm_dat_ready", dat_ready, 0);
        chk("t6_imm_rid", rid, 0);
        chk("t6_imm_rdata", rdata, 0);
        chk("t6_imm_rlast", rlast, 0);
        tick(); tick();
        n_rst = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t6_post_rvalid", rvalid, 0);
        end
        chk("t6_no_new_beats", blog.size() - base, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
